// File: rtl/mem_pkg.sv
// Shared state encoding and default widths for the frame reader and its FIFO.
package mem_pkg;

    localparam int DEF_MEM_DATA_BITS = 32;
    localparam int DEF_ADDR_BITS     = 23;
    localparam int DEF_BURST_BITS    = 10;
    localparam int DEF_BURST_LEN     = 128;
    localparam int DEF_FIFO_AW       = 10;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_SPACE = 3'd1,
        ST_REQ        = 3'd2,
        ST_READ       = 3'd3,
        ST_DONE       = 3'd4
    } rd_state_t;

endpackage

// File: rtl/mem_sync_fifo.sv
// Single-clock FIFO with registered read data, synchronous flush and a drop
// strobe for writes that find the FIFO full.
module mem_sync_fifo
    import mem_pkg::*;
#(
    parameter int MEM_DATA_BITS = DEF_MEM_DATA_BITS,
    parameter int FIFO_AW       = DEF_FIFO_AW
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     flush_i,
    input  logic                     wr_en_i,
    input  logic [MEM_DATA_BITS-1:0] wr_data_i,
    input  logic                     rd_en_i,
    output logic [MEM_DATA_BITS-1:0] rd_data_o,
    output logic                     empty_o,
    output logic [FIFO_AW:0]         level_o,
    output logic                     drop_o
);
    localparam int              DEPTH_N = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH   = (FIFO_AW + 1)'(DEPTH_N);

    logic [MEM_DATA_BITS-1:0] mem_q [0:DEPTH_N-1];
    logic [FIFO_AW-1:0]       wr_ptr_q;
    logic [FIFO_AW-1:0]       rd_ptr_q;
    logic [FIFO_AW:0]         level_q;
    logic [MEM_DATA_BITS-1:0] rd_data_q;
    logic                     full_w;
    logic                     rd_ok_w;
    logic                     wr_ok_w;

    assign full_w  = (level_q == DEPTH);
    assign rd_ok_w = rd_en_i && (level_q != '0) && !flush_i;
    // A read in the same cycle frees the slot a write into a full FIFO needs.
    assign wr_ok_w = wr_en_i && !flush_i && (!full_w || rd_ok_w);
    assign drop_o  = wr_en_i && !flush_i && full_w && !rd_ok_w;

    always_ff @(posedge clk_i) begin
        if (wr_ok_w) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rd_data_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_ok_w) begin
                wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            end
            if (rd_ok_w) begin
                rd_ptr_q  <= rd_ptr_q + FIFO_AW'(1);
                rd_data_q <= mem_q[rd_ptr_q];
            end
            if (wr_ok_w && !rd_ok_w) begin
                level_q <= level_q + (FIFO_AW + 1)'(1);
            end else if (rd_ok_w && !wr_ok_w) begin
                level_q <= level_q - (FIFO_AW + 1)'(1);
            end
        end
    end

    assign rd_data_o = rd_data_q;
    assign level_o   = level_q;
    assign empty_o   = (level_q == '0);

endmodule

// File: rtl/mem_frame_reader.sv
// Reads a frame from memory as a sequence of bursts through an arbiter channel
// and buffers the words in a FIFO for a downstream consumer.
module mem_frame_reader
    import mem_pkg::*;
#(
    parameter int MEM_DATA_BITS = DEF_MEM_DATA_BITS,
    parameter int ADDR_BITS     = DEF_ADDR_BITS,
    parameter int BUSRT_BITS    = DEF_BURST_BITS,
    parameter int BURST_LEN     = DEF_BURST_LEN,
    parameter int FIFO_AW       = DEF_FIFO_AW
) (
    input  logic                     mem_clk,
    input  logic                     rst_n,
    input  logic                     frame_start,
    input  logic [ADDR_BITS-1:0]     base_addr,
    input  logic [ADDR_BITS-1:0]     frame_words,
    output logic                     rd_burst_req,
    output logic [BUSRT_BITS-1:0]    rd_burst_len,
    output logic [ADDR_BITS-1:0]     rd_burst_addr,
    input  logic                     rd_burst_data_valid,
    input  logic [MEM_DATA_BITS-1:0] rd_burst_data,
    input  logic                     rd_burst_finish,
    input  logic                     fifo_rd_en,
    output logic [MEM_DATA_BITS-1:0] fifo_rd_data,
    output logic                     fifo_empty,
    output logic [FIFO_AW:0]         fifo_level,
    output logic                     frame_done,
    output logic                     overflow_err
);
    localparam int DEPTH = 1 << FIFO_AW;

    rd_state_t             state_q;
    logic [ADDR_BITS-1:0]  base_q;
    logic [ADDR_BITS-1:0]  offset_q;
    logic [ADDR_BITS-1:0]  remaining_q;
    logic [ADDR_BITS-1:0]  pend_base_q;
    logic [ADDR_BITS-1:0]  pend_words_q;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [BUSRT_BITS-1:0] len_q;
    logic                  req_q;
    logic                  pending_q;
    logic                  done_q;
    logic                  ovf_q;

    logic                  in_burst_w;
    logic                  restart_w;
    logic                  last_w;
    logic                  fifo_wr_w;
    logic                  fifo_drop_w;
    logic [ADDR_BITS-1:0]  rs_base_w;
    logic [ADDR_BITS-1:0]  rs_words_w;
    logic [BUSRT_BITS-1:0] cur_len_w;
    logic [31:0]           free_w;

    assign in_burst_w = (state_q == ST_REQ) || (state_q == ST_READ);
    // An in-flight burst cannot be aborted, so a new frame waits for its finish.
    assign restart_w  = (frame_start && !in_burst_w)
                     || (in_burst_w && rd_burst_finish && (pending_q || frame_start));
    assign rs_base_w  = (pending_q && !frame_start) ? pend_base_q  : base_addr;
    assign rs_words_w = (pending_q && !frame_start) ? pend_words_q : frame_words;
    assign cur_len_w  = (remaining_q < ADDR_BITS'(BURST_LEN)) ? BUSRT_BITS'(remaining_q)
                                                              : BUSRT_BITS'(BURST_LEN);
    assign free_w     = 32'(DEPTH) - 32'(fifo_level);
    assign last_w     = (remaining_q == ADDR_BITS'(len_q));
    assign fifo_wr_w  = in_burst_w && rd_burst_data_valid && !pending_q;

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            offset_q     <= '0;
            remaining_q  <= '0;
            pend_base_q  <= '0;
            pend_words_q <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            req_q        <= 1'b0;
            pending_q    <= 1'b0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (frame_start) begin
                ovf_q <= 1'b0;
            end else if (fifo_drop_w) begin
                ovf_q <= 1'b1;
            end

            if (restart_w) begin
                state_q     <= ST_WAIT_SPACE;
                base_q      <= rs_base_w;
                remaining_q <= rs_words_w;
                offset_q    <= '0;
                pending_q   <= 1'b0;
                req_q       <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: state_q <= ST_IDLE;
                    ST_WAIT_SPACE: begin
                        if (remaining_q == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else if (free_w >= 32'(cur_len_w)) begin
                            state_q <= ST_REQ;
                            req_q   <= 1'b1;
                            len_q   <= cur_len_w;
                            addr_q  <= base_q + offset_q;
                        end
                    end
                    ST_REQ, ST_READ: begin
                        if (frame_start) begin
                            pending_q    <= 1'b1;
                            pend_base_q  <= base_addr;
                            pend_words_q <= frame_words;
                        end
                        if (rd_burst_finish) begin
                            req_q       <= 1'b0;
                            offset_q    <= offset_q + ADDR_BITS'(len_q);
                            remaining_q <= remaining_q - ADDR_BITS'(len_q);
                            if (last_w) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ST_WAIT_SPACE;
                            end
                        end else if (rd_burst_data_valid) begin
                            req_q   <= 1'b0;
                            state_q <= ST_READ;
                        end
                    end
                    ST_DONE: state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    mem_sync_fifo #(
        .MEM_DATA_BITS(MEM_DATA_BITS),
        .FIFO_AW      (FIFO_AW)
    ) u_fifo (
        .clk_i    (mem_clk),
        .rst_n_i  (rst_n),
        .flush_i  (restart_w),
        .wr_en_i  (fifo_wr_w),
        .wr_data_i(rd_burst_data),
        .rd_en_i  (fifo_rd_en),
        .rd_data_o(fifo_rd_data),
        .empty_o  (fifo_empty),
        .level_o  (fifo_level),
        .drop_o   (fifo_drop_w)
    );

    assign rd_burst_req  = req_q;
    assign rd_burst_len  = len_q;
    assign rd_burst_addr = addr_q;
    assign frame_done    = done_q;
    assign overflow_err  = ovf_q;

endmodule

// File: tb/tb_mem_frame_reader.sv
// Scoreboard bench for mem_frame_reader: an arbiter model serves bursts, a
// consumer drains the FIFO, and monitors compare against queued expectations.
module tb_mem_frame_reader;

    localparam int DW    = 32;
    localparam int AW    = 23;
    localparam int BB    = 10;
    localparam int BL    = 128;
    localparam int FAW   = 8;
    localparam int DEPTH = 256;

    logic          mem_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] frame_words = '0;
    logic          rd_burst_req;
    logic [BB-1:0] rd_burst_len;
    logic [AW-1:0] rd_burst_addr;
    logic          rd_burst_data_valid = 1'b0;
    logic [DW-1:0] rd_burst_data = '0;
    logic          rd_burst_finish = 1'b0;
    logic          fifo_rd_en = 1'b0;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_empty;
    logic [FAW:0]  fifo_level;
    logic          frame_done;
    logic          overflow_err;

    int            checks = 0;
    int            errors = 0;
    int            done_cnt = 0;
    bit            consume = 1'b0;
    bit            force_rd = 1'b0;
    bit            ovf_en = 1'b0;
    logic [AW-1:0] ovf_addr = '0;
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] exp_baddr[$];
    logic [BB-1:0] exp_blen[$];

    mem_frame_reader #(
        .MEM_DATA_BITS(DW),
        .ADDR_BITS    (AW),
        .BUSRT_BITS   (BB),
        .BURST_LEN    (BL),
        .FIFO_AW      (FAW)
    ) dut (
        .mem_clk            (mem_clk),
        .rst_n              (rst_n),
        .frame_start        (frame_start),
        .base_addr          (base_addr),
        .frame_words        (frame_words),
        .rd_burst_req       (rd_burst_req),
        .rd_burst_len       (rd_burst_len),
        .rd_burst_addr      (rd_burst_addr),
        .rd_burst_data_valid(rd_burst_data_valid),
        .rd_burst_data      (rd_burst_data),
        .rd_burst_finish    (rd_burst_finish),
        .fifo_rd_en         (fifo_rd_en),
        .fifo_rd_data       (fifo_rd_data),
        .fifo_empty         (fifo_empty),
        .fifo_level         (fifo_level),
        .frame_done         (frame_done),
        .overflow_err       (overflow_err)
    );

    always #5 mem_clk = ~mem_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {9'h1A0, a};
    endfunction

    task automatic push_burst(input logic [AW-1:0] a, input logic [BB-1:0] l);
        exp_baddr.push_back(a);
        exp_blen.push_back(l);
    endtask

    task automatic push_words(input logic [AW-1:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(pat(base + AW'(i)));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge mem_clk);
        #1;
    endtask

    task automatic start_frame(input logic [AW-1:0] b, input logic [AW-1:0] w);
        cyc(1);
        base_addr   = b;
        frame_words = w;
        frame_start = 1'b1;
        cyc(1);
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max);
        int n = 0;
        while (frame_done !== 1'b1 && n < max) begin
            cyc(1);
            n++;
        end
        chk(name, 64'(frame_done), 64'd1);
    endtask

    task automatic wait_drain(input string name, input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            cyc(1);
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_level(input string name, input int lvl, input int max);
        int n = 0;
        while (int'(fifo_level) != lvl && n < max) begin
            cyc(1);
            n++;
        end
        chk(name, 64'(fifo_level), 64'(lvl));
    endtask

    task automatic wait_neg(input string name, input bit on_finish, input int max);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < max) begin
            @(negedge mem_clk);
            seen = on_finish ? rd_burst_finish : rd_burst_data_valid;
            n++;
        end
        chk(name, 64'(seen), 64'd1);
    endtask

    task automatic run_030(input string tag);
        int d0;
        push_burst(23'h000100, 10'd128);
        push_burst(23'h000180, 10'd128);
        push_burst(23'h000200, 10'd44);
        push_words(23'h000100, 300);
        d0 = done_cnt;
        start_frame(23'h000100, 23'd300);
        wait_done({tag, "_done"}, 3000);
        wait_drain({tag, "_drain"}, 600);
        cyc(3);
        chk({tag, "_done_cnt"}, 64'(done_cnt - d0), 64'd1);
        chk({tag, "_bursts_left"}, 64'(exp_baddr.size()), 64'd0);
    endtask

    // Arbiter model: two cycles of grant latency, then len words, then finish.
    initial begin
        logic [AW-1:0] a;
        logic [BB-1:0] l;
        int            n;
        forever begin
            cyc(1);
            if (rst_n && rd_burst_req) begin
                a = rd_burst_addr;
                l = rd_burst_len;
                if (exp_baddr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_burst: actual addr=%0h len=%0d required none", a, l);
                end else begin
                    chk("burst_addr", 64'(a), 64'(exp_baddr.pop_front()));
                    chk("burst_len", 64'(l), 64'(exp_blen.pop_front()));
                end
                chk("burst_space", 64'((DEPTH - int'(fifo_level)) >= int'(l)), 64'd1);
                n = int'(l) + ((ovf_en && a == ovf_addr) ? 1 : 0);
                cyc(2);
                for (int i = 0; i < n && rst_n; i++) begin
                    rd_burst_data_valid = 1'b1;
                    rd_burst_data       = pat(a + AW'(i));
                    cyc(1);
                end
                rd_burst_data_valid = 1'b0;
                if (rst_n) begin
                    rd_burst_finish = 1'b1;
                    cyc(1);
                    rd_burst_finish = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            cyc(1);
            fifo_rd_en = force_rd || (consume && !fifo_empty);
        end
    end

    // Read-data monitor: a read accepted at an edge shows its word just after it.
    initial begin
        forever begin
            @(negedge mem_clk);
            if (rst_n && fifo_rd_en && !fifo_empty) begin
                cyc(1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read: actual=%0h required none", fifo_rd_data);
                end else begin
                    chk("fifo_data", 64'(fifo_rd_data), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge mem_clk);
            if (frame_done) done_cnt++;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int req_hi;

        cyc(3);
        chk("rst_req", 64'(rd_burst_req), 64'd0);
        chk("rst_len", 64'(rd_burst_len), 64'd0);
        chk("rst_addr", 64'(rd_burst_addr), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_empty", 64'(fifo_empty), 64'd1);
        chk("rst_rdata", 64'(fifo_rd_data), 64'd0);
        chk("rst_done", 64'(frame_done), 64'd0);
        chk("rst_ovf", 64'(overflow_err), 64'd0);
        rst_n = 1'b1;

        force_rd = 1'b1;
        cyc(3);
        force_rd = 1'b0;
        cyc(2);
        chk("empty_rd_level", 64'(fifo_level), 64'd0);
        chk("empty_rd_empty", 64'(fifo_empty), 64'd1);

        consume = 1'b1;
        run_030("t030");

        d0 = done_cnt;
        start_frame(23'h000500, 23'd0);
        chk("zero_done_c1", 64'(frame_done), 64'd0);
        cyc(1);
        chk("zero_done_c2", 64'(frame_done), 64'd1);
        cyc(1);
        chk("zero_done_c3", 64'(frame_done), 64'd0);
        cyc(2);
        chk("zero_done_cnt", 64'(done_cnt - d0), 64'd1);

        push_burst(23'h7FFFC0, 10'd128);
        push_words(23'h7FFFC0, 128);
        start_frame(23'h7FFFC0, 23'd128);
        wait_done("wrap1_done", 2000);
        wait_drain("wrap1_drain", 400);
        push_burst(23'h7FFFF0, 10'd128);
        push_burst(23'h000070, 10'd128);
        push_words(23'h7FFFF0, 256);
        start_frame(23'h7FFFF0, 23'd256);
        wait_done("wrap2_done", 2000);
        wait_drain("wrap2_drain", 400);

        consume = 1'b0;
        cyc(2);
        for (int k = 0; k < 8; k++) push_burst(23'h004000 + AW'(128 * k), 10'd128);
        push_words(23'h004000, 1024);
        start_frame(23'h004000, 23'd1024);
        wait_level("stall_level", 256, 1000);
        req_hi = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (rd_burst_req) req_hi++;
        end
        chk("stall_req_cycles", 64'(req_hi), 64'd0);
        chk("stall_level_held", 64'(fifo_level), 64'd256);
        chk("stall_ovf", 64'(overflow_err), 64'd0);
        consume = 1'b1;
        wait_done("stall_done", 4000);
        wait_drain("stall_drain", 600);
        chk("stall_ovf_end", 64'(overflow_err), 64'd0);

        consume = 1'b0;
        cyc(2);
        push_burst(23'h001000, 10'd128);
        push_burst(23'h002000, 10'd64);
        start_frame(23'h001000, 23'd128);
        wait_neg("abort_valid_seen", 1'b0, 200);
        cyc(5);
        d0 = done_cnt;
        start_frame(23'h002000, 23'd64);
        wait_neg("abort_finish_seen", 1'b1, 400);
        cyc(1);
        chk("abort_level_restart", 64'(fifo_level), 64'd0);
        chk("abort_done_low", 64'(frame_done), 64'd0);
        push_words(23'h002000, 64);
        consume = 1'b1;
        wait_done("abort_done", 1000);
        wait_drain("abort_drain", 300);
        cyc(2);
        chk("abort_done_cnt", 64'(done_cnt - d0), 64'd1);

        consume = 1'b0;
        cyc(2);
        ovf_en   = 1'b1;
        ovf_addr = 23'h003080;
        push_burst(23'h003000, 10'd128);
        push_burst(23'h003080, 10'd128);
        start_frame(23'h003000, 23'd256);
        wait_done("ovf_done", 2000);
        chk("ovf_level_full", 64'(fifo_level), 64'd256);
        chk("ovf_flag_set", 64'(overflow_err), 64'd1);
        ovf_en = 1'b0;
        cyc(3);
        chk("ovf_flag_sticky", 64'(overflow_err), 64'd1);
        start_frame(23'h003000, 23'd0);
        chk("ovf_flag_cleared", 64'(overflow_err), 64'd0);
        chk("ovf_level_flushed", 64'(fifo_level), 64'd0);
        cyc(1);
        chk("ovf_zero_done", 64'(frame_done), 64'd1);

        consume = 1'b1;
        cyc(2);
        push_burst(23'h000100, 10'd128);
        push_burst(23'h000180, 10'd128);
        push_burst(23'h000200, 10'd44);
        push_words(23'h000100, 300);
        start_frame(23'h000100, 23'd300);
        wait_neg("rstmid_valid_seen", 1'b0, 200);
        cyc(10);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid_req", 64'(rd_burst_req), 64'd0);
        chk("rstmid_len", 64'(rd_burst_len), 64'd0);
        chk("rstmid_addr", 64'(rd_burst_addr), 64'd0);
        chk("rstmid_level", 64'(fifo_level), 64'd0);
        chk("rstmid_empty", 64'(fifo_empty), 64'd1);
        chk("rstmid_rdata", 64'(fifo_rd_data), 64'd0);
        chk("rstmid_done", 64'(frame_done), 64'd0);
        chk("rstmid_ovf", 64'(overflow_err), 64'd0);
        exp_q.delete();
        exp_baddr.delete();
        exp_blen.delete();
        cyc(3);
        rst_n = 1'b1;
        cyc(3);
        run_030("t035");

        cyc(5);
        chk("final_words_left", 64'(exp_q.size()), 64'd0);
        chk("final_bursts_left", 64'(exp_baddr.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
